audio_channel_mixer: RTL

- Time-multiplexed N-channel audio mixer that turns per-channel unsigned emulator voice samples (GB/NES 4-bit style) into signed 24-bit stereo words for the I2S transmitter.
- One mix per sample strobe (e.g. an LRCLK-derived 48 kHz pulse): snapshot inputs, MAC one channel per cycle into L/R accumulators, apply master volume and shift, saturate, present with a one-cycle valid.
- Successor to the fixed per-design mixing: channel count, sample width, volume width and output scaling are parameters; adds per-channel panning, mute, saturation and overrun detection.

---
 rtl/audio_channel_mixer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/audio_channel_mixer.sv
// Time-multiplexed N-channel audio mixer: snapshots unsigned voice samples on a
// strobe, MACs one channel per cycle into L/R accumulators, scales, saturates.
module audio_channel_mixer #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 4,
  parameter int VOL_W  = 5,
  parameter int OUT_W  = 24,
  parameter int SHIFT  = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_strobe,
  input  logic [NUM_CH*IN_W-1:0]   ch_samples,
  input  logic [NUM_CH-1:0]        ch_enable_l,
  input  logic [NUM_CH-1:0]        ch_enable_r,
  input  logic [VOL_W-1:0]         volume,
  input  logic                     mute,
  input  logic                     clear_overrun,
  output logic [OUT_W-1:0]         out_l,
  output logic [OUT_W-1:0]         out_r,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W  = IN_W + VOL_W + 1 + $clog2(NUM_CH) + 1;
  localparam int WIDE_W = ACC_W + SHIFT;
  localparam int SAT_W  = ((WIDE_W > OUT_W) ? WIDE_W : OUT_W) + 1;

  localparam logic signed [SAT_W-1:0] MAX_V = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] MIN_V = {{(SAT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         idx;
  logic [NUM_CH*IN_W-1:0]   snap_samples;
  logic [NUM_CH-1:0]        snap_en_l;
  logic [NUM_CH-1:0]        snap_en_r;
  logic [VOL_W-1:0]         snap_vol;
  logic                     snap_mute;
  logic signed [ACC_W-1:0]  acc_l, acc_r;

  logic                     start;
  logic                     last_ch;
  logic [IN_W-1:0]          cur_sample;
  logic signed [ACC_W-1:0]  s_w, v_w, p_w;
  logic signed [SAT_W-1:0]  wide_l, wide_r;

  assign start   = sample_strobe && (state == IDLE);
  assign last_ch = (idx == IDX_W'(NUM_CH - 1));

  // Offset-binary sample to signed, then scale by the unsigned master volume.
  always_comb begin
    cur_sample = snap_samples[int'(idx)*IN_W +: IN_W];
    s_w        = $signed({{(ACC_W-IN_W){1'b0}}, cur_sample}) - $signed(ACC_W'(1) << (IN_W - 1));
    v_w        = $signed({{(ACC_W-VOL_W){1'b0}}, snap_vol});
    p_w        = s_w * v_w;
    wide_l     = $signed({{(SAT_W-ACC_W){acc_l[ACC_W-1]}}, acc_l}) <<< SHIFT;
    wide_r     = $signed({{(SAT_W-ACC_W){acc_r[ACC_W-1]}}, acc_r}) <<< SHIFT;
  end

  function automatic logic [OUT_W-1:0] sat(input logic signed [SAT_W-1:0] w);
    if (w > MAX_V)      return MAX_V[OUT_W-1:0];
    else if (w < MIN_V) return MIN_V[OUT_W-1:0];
    else                return w[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = ACCUM;
      ACCUM:   if (last_ch) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      snap_samples <= '0;
      snap_en_l    <= '0;
      snap_en_r    <= '0;
      snap_vol     <= '0;
      snap_mute    <= 1'b0;
      acc_l        <= '0;
      acc_r        <= '0;
      out_l        <= '0;
      out_r        <= '0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          snap_samples <= ch_samples;
          snap_en_l    <= ch_enable_l;
          snap_en_r    <= ch_enable_r;
          snap_vol     <= volume;
          snap_mute    <= mute;
          acc_l        <= '0;
          acc_r        <= '0;
          idx          <= '0;
        end
        ACCUM: begin
          if (snap_en_l[idx]) acc_l <= acc_l + p_w;
          if (snap_en_r[idx]) acc_r <= acc_r + p_w;
          idx <= idx + 1'b1;
        end
        FINISH: begin
          out_l     <= snap_mute ? '0 : sat(wide_l);
          out_r     <= snap_mute ? '0 : sat(wide_r);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A strobe that arrives while a mix is running wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                overrun <= 1'b0;
    else if (sample_strobe && state != IDLE)   overrun <= 1'b1;
    else if (clear_overrun)                    overrun <= 1'b0;
  end

endmodule
